// File: rtl/cordic_vec_ctrl.sv
// Control sequencer for the iterative CORDIC vectoring datapath: start/fold capture,
// per-clock micro-rotation stepping and output-load/done strobes. Optional abort via CORDIC_CTRL_ABORT_EN.
module cordic_vec_ctrl #(
    parameter int num_width  = 16,
    parameter int iterations = 12,
    parameter int idx_width  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 x_sign,
    input  logic                 y_sign,
`ifdef CORDIC_CTRL_ABORT_EN
    input  logic                 abort,
    output logic                 aborted,
`endif
    output logic                 ready,
    output logic                 busy,
    output logic                 ld_init,
    output logic                 fold,
    output logic                 iter_en,
    output logic [idx_width-1:0] iter_idx,
    output logic                 dir,
    output logic                 ld_out,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        ITER   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [idx_width-1:0] last_idx = idx_width'(iterations - 1);
    localparam logic [idx_width-1:0] one_idx  = idx_width'(1);

    // Elaboration-time guard: the index must be able to hold iterations-1.
    generate
        if (num_width < 1 || iterations < 1 || iterations > (1 << idx_width)) begin : g_bad_cfg
            $error("cordic_vec_ctrl: illegal parameter combination");
        end
    endgenerate

    state_t state;
    logic   ld_out_q;
    logic   done_q;
    logic   kill;

`ifdef CORDIC_CTRL_ABORT_EN
    assign kill    = abort & (state != IDLE);
    assign aborted = kill;
    assign ld_out  = ld_out_q & ~kill;
    assign done    = done_q & ~kill;
`else
    assign kill    = 1'b0;
    assign ld_out  = ld_out_q;
    assign done    = done_q;
`endif

    // Direction only means something while a micro-rotation is in progress.
    assign dir = iter_en & y_sign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            iter_idx <= '0;
            fold     <= 1'b0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            ld_init  <= 1'b0;
            iter_en  <= 1'b0;
            ld_out_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            ld_init  <= 1'b0;
            ld_out_q <= 1'b0;
            done_q   <= 1'b0;
            if (kill) begin
                state   <= IDLE;
                ready   <= 1'b1;
                busy    <= 1'b0;
                iter_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= INIT;
                            fold    <= x_sign;
                            ready   <= 1'b0;
                            busy    <= 1'b1;
                            ld_init <= 1'b1;
                        end
                    end
                    INIT: begin
                        state    <= ITER;
                        iter_idx <= '0;
                        iter_en  <= 1'b1;
                    end
                    ITER: begin
                        // Terminal compare holds the index, so all-ones never wraps.
                        if (iter_idx == last_idx) begin
                            state    <= FINISH;
                            iter_en  <= 1'b0;
                            ld_out_q <= 1'b1;
                            done_q   <= 1'b1;
                        end else begin
                            iter_idx <= iter_idx + one_idx;
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        iter_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cordic_vec_ctrl.sv
// Directed bench for cordic_vec_ctrl: default (12), single-iteration and full-range (16) instances.
// Exercises the abort path when CORDIC_CTRL_ABORT_EN is defined.
module tb_cordic_vec_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic x_sign = 1'b0;
    logic y_sign = 1'b0;
    logic abort = 1'b0;

    logic a_ready, a_busy, a_ld_init, a_fold, a_iter_en, a_dir, a_ld_out, a_done, a_aborted;
    logic b_ready, b_busy, b_ld_init, b_fold, b_iter_en, b_dir, b_ld_out, b_done, b_aborted;
    logic c_ready, c_busy, c_ld_init, c_fold, c_iter_en, c_dir, c_ld_out, c_done, c_aborted;
    logic [3:0] a_idx, b_idx, c_idx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cordic_vec_ctrl #(.num_width(16), .iterations(12), .idx_width(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .x_sign(x_sign), .y_sign(y_sign),
`ifdef CORDIC_CTRL_ABORT_EN
        .abort(abort), .aborted(a_aborted),
`endif
        .ready(a_ready), .busy(a_busy), .ld_init(a_ld_init), .fold(a_fold), .iter_en(a_iter_en),
        .iter_idx(a_idx), .dir(a_dir), .ld_out(a_ld_out), .done(a_done)
    );

    cordic_vec_ctrl #(.num_width(16), .iterations(1), .idx_width(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .x_sign(x_sign), .y_sign(y_sign),
`ifdef CORDIC_CTRL_ABORT_EN
        .abort(abort), .aborted(b_aborted),
`endif
        .ready(b_ready), .busy(b_busy), .ld_init(b_ld_init), .fold(b_fold), .iter_en(b_iter_en),
        .iter_idx(b_idx), .dir(b_dir), .ld_out(b_ld_out), .done(b_done)
    );

    cordic_vec_ctrl #(.num_width(16), .iterations(16), .idx_width(4)) dut_c (
        .clk(clk), .rst(rst), .start(start), .x_sign(x_sign), .y_sign(y_sign),
`ifdef CORDIC_CTRL_ABORT_EN
        .abort(abort), .aborted(c_aborted),
`endif
        .ready(c_ready), .busy(c_busy), .ld_init(c_ld_init), .fold(c_fold), .iter_en(c_iter_en),
        .iter_idx(c_idx), .dir(c_dir), .ld_out(c_ld_out), .done(c_done)
    );

`ifndef CORDIC_CTRL_ABORT_EN
    assign a_aborted = 1'b0;
    assign b_aborted = 1'b0;
    assign c_aborted = 1'b0;
`endif

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_a(input string tag, input int exp_fold);
        check({tag, "_ready"}, a_ready, 1);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_ld_init"}, a_ld_init, 0);
        check({tag, "_iter_en"}, a_iter_en, 0);
        check({tag, "_dir"}, a_dir, 0);
        check({tag, "_ld_out"}, a_ld_out, 0);
        check({tag, "_done"}, a_done, 0);
        check({tag, "_fold"}, a_fold, exp_fold);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One operation on the 12-iteration instance; k counts negedges after the start-sampling edge.
    task automatic run_op_a(input logic xs, input bit inject, output int dn);
        int exp_idx;
        bit exp_iter;
        dn = 0;
        @(negedge clk);
        start = 1'b1;
        x_sign = xs;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            start = (inject && k == 5);
            x_sign = ~xs;
            y_sign = k[0];
            #1;
            exp_iter = (k >= 2 && k <= 13);
            exp_idx = exp_iter ? k - 2 : 11;
            if (a_done) dn++;
            check($sformatf("op_ld_init_k%0d", k), a_ld_init, int'(k == 1));
            check($sformatf("op_iter_en_k%0d", k), a_iter_en, int'(exp_iter));
            if (k >= 2) check($sformatf("op_idx_k%0d", k), a_idx, exp_idx);
            check($sformatf("op_dir_k%0d", k), a_dir, int'(exp_iter && k[0]));
            check($sformatf("op_done_k%0d", k), a_done, int'(k == 14));
            check($sformatf("op_ld_out_k%0d", k), a_ld_out, int'(k == 14));
            check($sformatf("op_busy_k%0d", k), a_busy, int'(k <= 14));
            check($sformatf("op_ready_k%0d", k), a_ready, int'(k >= 15));
            check($sformatf("op_fold_k%0d", k), a_fold, int'(xs));
        end
    endtask

    initial begin
        int dn;
        int t;
        int ndone;
        int dt[3];
        int found;
        int cnt_b, cnt_c, dn_b, dn_c, idx_err, idx_done_b, idx_done_c;

        // Reset and idle
        @(negedge clk);
        #1;
        check_idle_a("rst", 0);
        check("rst_idx", a_idx, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check_idle_a($sformatf("idle%0d", i), 0);
            check($sformatf("idle%0d_idx", i), a_idx, 0);
        end

        // Plain operation, then folded operation with a stray start during ITER
        run_op_a(1'b0, 1'b0, dn);
        check("op0_done_count", dn, 1);
        run_op_a(1'b1, 1'b1, dn);
        check("op1_done_count", dn, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_idle_a($sformatf("post_fold%0d", i), 1);
        end

        // Back-to-back with start held high
        do_reset();
        start = 1'b1;
        ndone = 0;
        for (int c = 0; c < 60 && ndone < 3; c++) begin
            @(negedge clk);
            #1;
            if (a_done) begin
                dt[ndone] = c;
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b_count", ndone, 3);
        if (ndone == 3) begin
            check("b2b_gap0", dt[1] - dt[0], 15);
            check("b2b_gap1", dt[2] - dt[1], 15);
        end

        // Async reset mid-operation
        do_reset();
        repeat (3) @(negedge clk);
        start = 1'b1;
        x_sign = 1'b1;
        y_sign = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            @(negedge clk);
            #1;
            if (a_iter_en && a_idx == 4'd5) found = 1;
        end
        check("arst_reach_idx5", found, 1);
        rst = 1'b1;
        #1;
        check_idle_a("arst", 0);
        check("arst_idx", a_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (a_done || a_ld_out) dn++;
        end
        check("arst_no_done", dn, 0);

        // iterations=1 and iterations=16 instances
        do_reset();
        y_sign = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt_b = 0; cnt_c = 0; dn_b = 0; dn_c = 0; idx_err = 0;
        idx_done_b = -1; idx_done_c = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (b_iter_en) cnt_b++;
            if (c_iter_en) begin
                if (c_idx != cnt_c[3:0]) idx_err++;
                cnt_c++;
            end
            if (b_done) begin dn_b++; idx_done_b = b_idx; end
            if (c_done) begin dn_c++; idx_done_c = c_idx; end
        end
        check("it1_iter_cycles", cnt_b, 1);
        check("it1_done_count", dn_b, 1);
        check("it1_idx_at_done", idx_done_b, 0);
        check("it16_iter_cycles", cnt_c, 16);
        check("it16_idx_seq_err", idx_err, 0);
        check("it16_done_count", dn_c, 1);
        check("it16_idx_at_done", idx_done_c, 15);
        check("it16_ready_after", c_ready, 1);

`ifdef CORDIC_CTRL_ABORT_EN
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            @(negedge clk);
            #1;
            if (a_iter_en && a_idx == 4'd3) found = 1;
        end
        check("abort_reach_idx3", found, 1);
        abort = 1'b1;
        #1;
        check("abort_pulse", a_aborted, 1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_pulse_end", a_aborted, 0);
        check("abort_ready", a_ready, 1);
        check("abort_busy", a_busy, 0);
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (a_done || a_ld_out) dn++;
        end
        check("abort_no_done", dn, 0);
`endif

        t = checks;
        $display("TB_RESULT checks=%0d failures=%0d", t, failures);
        $finish;
    end

endmodule
